// File: rtl/regfile_arbiter.sv
// regfile_arbiter
//   Two-requester write arbiter in front of a register-file write port, plus
//   a display-address scanner.
//
//   Requester 0 is the CPU writeback path and requester 1 is the board/debug
//   loader. Requester 1 can take the port exclusively by holding req1_lock.
//   One request is accepted per cycle. Each accepted request appears on the
//   write port exactly one cycle later. A request whose address has
//   addr[4:3] != 0 is still accepted, but it produces an addr_err pulse and
//   no write.
//
// Handshake: a requester's request is taken on a rising clock edge only when
//   its valid and its ready are both high at that edge. The ready signals are
//   combinational, mutually exclusive, never high without the matching valid,
//   and held low while reset is asserted.
//
// Ports
//   clock_in                          single clock, all state on posedge
//   rst                               asynchronous reset, active low
//   req0_valid/addr/data, req0_ready  requester 0 write request
//   req1_valid/addr/data/lock,
//   req1_ready                        requester 1 write request and lock
//   regWrite/writeReg/writeData       register-file write port
//   grant_id                          owner of the current regWrite beat
//   addr_err                          one-cycle pulse for a dropped request
//   scan_en, sel_addr, showAddress    display address control
//   lockState                         debug: 1 while the arbiter FSM is in LOCK1
module regfile_arbiter #(
    parameter int SCAN_DIV = 50000000,
    parameter int DATA_W   = 32
) (
    input  logic              clock_in,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [4:0]        req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [4:0]        req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              req1_lock,
    output logic              req1_ready,
    output logic              regWrite,
    output logic [4:0]        writeReg,
    output logic [DATA_W-1:0] writeData,
    output logic              grant_id,
    output logic              addr_err,
    input  logic              scan_en,
    input  logic [2:0]        sel_addr,
    output logic [2:0]        showAddress,
    output logic              lockState
);

    typedef enum logic {
        IDLE  = 1'b0,
        LOCK1 = 1'b1
    } state_t;

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    state_t            state;
    state_t            nextState;
    logic              rrPref;      // requester that wins when both are valid
    logic              grant0;
    logic              grant1;
    logic              accept;
    logic [4:0]        acceptAddr;
    logic [DATA_W-1:0] acceptData;
    logic              addrLegal;
    logic [CNT_W-1:0]  scanCnt;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock_in or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. The lock is released on the first cycle req1_lock
    // drops, whether or not req1 is presenting a request.
    // ------------------------------------------------------------------
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (grant1 && req1_lock) nextState = LOCK1;
            LOCK1:   if (!req1_lock)          nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (grants). The lock only takes effect while req1_lock is
    // still high. That lets req0 be granted on the same cycle the lock
    // drops.
    // ------------------------------------------------------------------
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst) begin
            if (state == LOCK1 && req1_lock) begin
                grant1 = req1_valid;
            end else if (req0_valid && req1_valid) begin
                grant0 = ~rrPref;
                grant1 = rrPref;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign lockState  = (state == LOCK1);

    assign accept     = grant0 | grant1;
    assign acceptAddr = grant1 ? req1_addr : req0_addr;
    assign acceptData = grant1 ? req1_data : req0_data;
    assign addrLegal  = (acceptAddr[4:3] == 2'b00);

    // Round-robin pointer: after a grant, prefer the other requester.
    always_ff @(posedge clock_in or negedge rst) begin
        if (!rst) begin
            rrPref <= 1'b0;
        end else if (accept) begin
            rrPref <= ~grant1;
        end
    end

    // ------------------------------------------------------------------
    // Write port. The address, data and id registers only load on a legal
    // accept, so they keep the last beat's values between writes.
    // ------------------------------------------------------------------
    always_ff @(posedge clock_in or negedge rst) begin
        if (!rst) begin
            regWrite  <= 1'b0;
            addr_err  <= 1'b0;
            writeReg  <= '0;
            writeData <= '0;
            grant_id  <= 1'b0;
        end else begin
            regWrite <= accept && addrLegal;
            addr_err <= accept && !addrLegal;
            if (accept && addrLegal) begin
                writeReg  <= acceptAddr;
                writeData <= acceptData;
                grant_id  <= grant1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Display address. While scanning, the address steps every SCAN_DIV
    // cycles. While not scanning, the address follows sel_addr and the
    // counter sits at 0, so scanning resumes from the shown address.
    // ------------------------------------------------------------------
    always_ff @(posedge clock_in or negedge rst) begin
        if (!rst) begin
            scanCnt     <= '0;
            showAddress <= '0;
        end else if (scan_en) begin
            if (scanCnt == CNT_LAST) begin
                scanCnt     <= '0;
                showAddress <= showAddress + 3'd1;
            end else begin
                scanCnt <= scanCnt + 1'b1;
            end
        end else begin
            scanCnt     <= '0;
            showAddress <= sel_addr;
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter. Runs directed scenarios and then a randomized
// phase. The expected write beats are queued at issue time. A monitor process
// pops and compares them whenever the DUT shows a beat.
module tb_regfile_arbiter;

    localparam int DW = 32;
    localparam int SD = 4;

    logic          clock_in = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0;
    logic [4:0]    req0_addr = '0;
    logic [DW-1:0] req0_data = '0;
    logic          req0_ready;
    logic          req1_valid = 1'b0;
    logic [4:0]    req1_addr = '0;
    logic [DW-1:0] req1_data = '0;
    logic          req1_lock = 1'b0;
    logic          req1_ready;
    logic          regWrite;
    logic [4:0]    writeReg;
    logic [DW-1:0] writeData;
    logic          grant_id;
    logic          addr_err;
    logic          scan_en = 1'b0;
    logic [2:0]    sel_addr = '0;
    logic [2:0]    showAddress;
    logic          lockState;

    regfile_arbiter #(.SCAN_DIV(SD), .DATA_W(DW)) dut (
        .clock_in(clock_in), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
        .req1_lock(req1_lock), .req1_ready(req1_ready),
        .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
        .grant_id(grant_id), .addr_err(addr_err),
        .scan_en(scan_en), .sel_addr(sel_addr), .showAddress(showAddress),
        .lockState(lockState)
    );

    // ---------------- clock ----------------
    always #5 clock_in = ~clock_in;

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic [31:0]   tag;   // cycle on which the beat must appear
        logic          err;
        logic          id;
        logic [4:0]    addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: who is owed the next contended grant, whether req1
    // owns the port, the last written beat, and the scan position.
    bit            mPref = 1'b0;
    bit            mLocked = 1'b0;
    logic [4:0]    mLastReg = '0;
    logic [DW-1:0] mLastData = '0;
    logic          mLastId = 1'b0;
    logic [2:0]    mBase = '0;
    int            mCount = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] exp_show();
        return mBase + 3'(mCount / SD);
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input bit v0, input logic [4:0] a0, input logic [DW-1:0] d0,
                         input bit v1, input logic [4:0] a1, input logic [DW-1:0] d1,
                         input bit lk);
        bit e0, e1;
        exp_t e;
        @(negedge clock_in);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1; req1_lock = lk;
        #1;
        e0 = 1'b0;
        e1 = 1'b0;
        if (rst) begin
            if (mLocked && lk) e1 = v1;
            else if (v0 && v1) begin e0 = !mPref; e1 = mPref; end
            else begin e0 = v0; e1 = v1; end
        end
        check("req0_ready", req0_ready, e0);
        check("req1_ready", req1_ready, e1);
        if (e0 || e1) begin
            e.tag  = cyc + 1;
            e.id   = e1;
            e.addr = e1 ? a1 : a0;
            e.data = e1 ? d1 : d0;
            e.err  = (e.addr >= 5'd8);
            exp_q.push_back(e);
            mPref = !e1;
        end
        if (rst) begin
            if (e1 && lk) mLocked = 1'b1;
            else if (!lk) mLocked = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 5'd0, '0, 0, 5'd0, '0, 0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clock_in);
            cyc++;
            if (!rst) begin
                mBase = '0; mCount = 0;
            end else if (scan_en) begin
                mCount++;
            end else begin
                mBase = sel_addr; mCount = 0;
            end
            #1;
            check("showAddress", showAddress, exp_show());
            check("lockState", lockState, mLocked);
            if (regWrite || addr_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {regWrite, addr_err}, 2'b00);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_cycle", e.tag, cyc);
                    check("beat_kind", {regWrite, addr_err}, e.err ? 2'b01 : 2'b10);
                    if (!e.err) begin
                        check("beat_payload", {grant_id, writeReg, writeData}, {e.id, e.addr, e.data});
                        mLastReg = e.addr; mLastData = e.data; mLastId = e.id;
                    end
                end
            end else begin
                if (exp_q.size() != 0 && exp_q[0].tag <= cyc) begin
                    e = exp_q.pop_front();
                    check("missing_beat", {regWrite, addr_err}, e.err ? 2'b01 : 2'b10);
                end
            end
            if (!regWrite)
                check("hold_values", {grant_id, writeReg, writeData}, {mLastId, mLastReg, mLastData});
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit v0, v1, lk;
        logic [4:0] a0, a1;

        // Asynchronous reset before the first edge.
        #1 rst = 1'b0;
        #1;
        check("reset_outputs", {regWrite, writeReg, writeData, grant_id, addr_err, showAddress}, '0);
        check("reset_readies", {req0_ready, req1_ready}, 2'b00);
        idle(2);
        @(negedge clock_in) rst = 1'b1;

        // Both requesters valid continuously: grants alternate 0,1,0,...
        for (int i = 0; i < 6; i++) drive(1, 5'd3, 32'hA, 1, 5'd5, 32'hB, 0);
        idle(1);

        // Lock: make req0 the last grant so req1 wins the contended first beat.
        drive(1, 5'd1, 32'h11, 0, 5'd0, '0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'd1, 32'h12, 1, 5'd2, 32'h20 + i, 1);
            check("lock_req0_blocked", req0_ready, 1'b0);
        end
        drive(1, 5'd1, 32'h13, 0, 5'd2, '0, 1);
        check("lock_req0_blocked_idle1", req0_ready, 1'b0);
        drive(1, 5'd1, 32'h14, 0, 5'd2, '0, 0);
        check("unlock_req0_grant", req0_ready, 1'b1);
        idle(1);

        // Illegal address: accepted, then one error pulse with no write.
        drive(1, 5'h09, 32'hDEAD, 0, 5'd0, '0, 0);
        check("illegal_accepted", req0_ready, 1'b1);
        @(posedge clock_in); #2;
        check("illegal_pulse", {regWrite, addr_err}, 2'b01);
        idle(1);
        @(posedge clock_in); #2;
        check("illegal_pulse_one_cycle", addr_err, 1'b0);

        // Scanner: 40 cycles of scanning, then load sel_addr=6.
        scan_en = 1'b1;
        idle(40);
        scan_en = 1'b0; sel_addr = 3'd6;
        idle(1);
        @(posedge clock_in); #2;
        check("sel_addr_load", showAddress, 3'd6);
        scan_en = 1'b1;
        idle(6);

        // Randomized traffic with occasional scan toggles.
        lk = 1'b0;
        for (int i = 0; i < 400; i++) begin
            v0 = ($urandom_range(0, 3) != 0);
            v1 = ($urandom_range(0, 2) != 0);
            a0 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
            a1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
            if ($urandom_range(0, 5) == 0) lk = !lk;
            if ($urandom_range(0, 29) == 0) scan_en = !scan_en;
            sel_addr = 3'($urandom_range(0, 7));
            drive(v0, a0, $urandom, v1, a1, $urandom, lk);
        end

        // Reset mid-stream while a req0 request is being accepted.
        drive(1, 5'd4, 32'h44, 0, 5'd0, '0, 0);
        #1 rst = 1'b0;
        #1;
        check("midreset_outputs", {regWrite, writeReg, writeData, grant_id, addr_err, showAddress}, '0);
        check("midreset_readies", {req0_ready, req1_ready}, 2'b00);
        exp_q.delete();
        mPref = 1'b0; mLocked = 1'b0;
        mLastReg = '0; mLastData = '0; mLastId = 1'b0;
        mBase = '0; mCount = 0;
        drive(1, 5'd4, 32'h45, 1, 5'd6, 32'h66, 1);
        drive(1, 5'd4, 32'h46, 1, 5'd6, 32'h67, 0);
        @(negedge clock_in);
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; req1_lock = 1'b0;
        drive(1, 5'd7, 32'h77, 1, 5'd2, 32'h22, 0);
        check("first_grant_after_reset", {req0_ready, req1_ready}, 2'b10);

        idle(3);
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
